// File: rtl/mico8_io_pkg.sv
// Shared definitions for the Mico8 I/O timer: register offsets, CTRL bit
// positions and the interrupt FSM state encoding.
package mico8_io_pkg;

  localparam logic [2:0] OFS_CTRL      = 3'd0;
  localparam logic [2:0] OFS_STATUS    = 3'd1;
  localparam logic [2:0] OFS_RELOAD_LO = 3'd2;
  localparam logic [2:0] OFS_RELOAD_HI = 3'd3;
  localparam logic [2:0] OFS_PRESC     = 3'd4;
  localparam logic [2:0] OFS_COUNT_LO  = 3'd5;
  localparam logic [2:0] OFS_COUNT_HI  = 3'd6;
  localparam logic [2:0] OFS_CMP       = 3'd7;

  localparam int unsigned CTRL_EN      = 0;
  localparam int unsigned CTRL_IE      = 1;
  localparam int unsigned CTRL_ONESHOT = 2;

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } irq_state_t;

endpackage

// File: rtl/mico8_io_regif.sv
// Address decode, register file and zero-latency read mux for mico8_io_timer.
// Optional CMP register at offset 7 when MICO8_TMR_PWM_EN is defined.
module mico8_io_regif
  import mico8_io_pkg::*;
#(
  parameter logic [7:0]  BASE_ADDR    = 8'h10,
  parameter logic [15:0] RESET_RELOAD = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  io_addr,
  input  logic [7:0]  io_wdata,
  input  logic        io_wr,
  input  logic        io_rd,
  output logic [7:0]  io_rdata,
  input  logic [15:0] count,
  input  logic        tc,
  input  logic        en_clr,
  output logic [2:0]  ctrl,
  output logic [15:0] reload,
  output logic [7:0]  presc,
`ifdef MICO8_TMR_PWM_EN
  output logic [7:0]  cmp,
`endif
  output logic        en_rise,
  output logic        tc_wclr
);

  logic       sel;
  logic [2:0] ofs;
  logic       wr_en;
  logic       rd_en;
  logic [7:0] shadow;

  assign sel   = (io_addr[7:3] == BASE_ADDR[7:3]);
  assign ofs   = io_addr[2:0];
  assign wr_en = io_wr && sel;
  assign rd_en = io_rd && sel;

  assign en_rise = wr_en && (ofs == OFS_CTRL) && io_wdata[CTRL_EN] && !ctrl[CTRL_EN];
  assign tc_wclr = wr_en && (ofs == OFS_STATUS) && io_wdata[0];

  // A firmware CTRL write in the same cycle as a one-shot expiry wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl   <= '0;
      reload <= RESET_RELOAD;
      presc  <= '0;
      shadow <= '0;
`ifdef MICO8_TMR_PWM_EN
      cmp    <= '0;
`endif
    end else begin
      if (en_clr) ctrl[CTRL_EN] <= 1'b0;
      if (wr_en) begin
        case (ofs)
          OFS_CTRL:      ctrl         <= io_wdata[2:0];
          OFS_RELOAD_LO: reload[7:0]  <= io_wdata;
          OFS_RELOAD_HI: reload[15:8] <= io_wdata;
          OFS_PRESC:     presc        <= io_wdata;
`ifdef MICO8_TMR_PWM_EN
          OFS_CMP:       cmp          <= io_wdata;
`endif
          default: ;
        endcase
      end
      if (rd_en && (ofs == OFS_COUNT_LO)) shadow <= count[15:8];
    end
  end

  always_comb begin
    io_rdata = '0;
    if (rd_en) begin
      case (ofs)
        OFS_CTRL:      io_rdata = {5'b0, ctrl};
        OFS_STATUS:    io_rdata = {7'b0, tc};
        OFS_RELOAD_LO: io_rdata = reload[7:0];
        OFS_RELOAD_HI: io_rdata = reload[15:8];
        OFS_PRESC:     io_rdata = presc;
        OFS_COUNT_LO:  io_rdata = count[7:0];
        OFS_COUNT_HI:  io_rdata = shadow;
`ifdef MICO8_TMR_PWM_EN
        OFS_CMP:       io_rdata = cmp;
`endif
        default:       io_rdata = '0;
      endcase
    end
  end

endmodule

// File: rtl/mico8_io_timer.sv
// I/O-mapped 16-bit timer and interrupt source for the Mico8 external port.
// Define MICO8_TMR_PWM_EN to add the CMP register and the pwm_out output.
module mico8_io_timer
  import mico8_io_pkg::*;
#(
  parameter logic [7:0]  BASE_ADDR    = 8'h10,
  parameter int unsigned PRESCALE_W   = 8,
  parameter logic [15:0] RESET_RELOAD = 16'hFFFF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] io_addr,
  input  logic [7:0] io_wdata,
  input  logic       io_wr,
  input  logic       io_rd,
  output logic [7:0] io_rdata,
  output logic       intr,
  input  logic       intr_ack,
  output logic       tick
`ifdef MICO8_TMR_PWM_EN
  ,output logic      pwm_out
`endif
);

  logic [2:0]            ctrl;
  logic [15:0]           reload;
  logic [7:0]            presc;
  logic                  en_rise;
  logic                  tc_wclr;
  logic [PRESCALE_W-1:0] pcnt;
  logic [15:0]           count;
  logic                  tc;
  logic                  ps_wrap;
  logic                  tc_set;
  logic                  tc_clr;
  irq_state_t            state, state_n;
`ifdef MICO8_TMR_PWM_EN
  logic [7:0]            cmp;
`endif

  mico8_io_regif #(
    .BASE_ADDR    (BASE_ADDR),
    .RESET_RELOAD (RESET_RELOAD)
  ) u_regif (
    .clk      (clk),
    .rst      (rst),
    .io_addr  (io_addr),
    .io_wdata (io_wdata),
    .io_wr    (io_wr),
    .io_rd    (io_rd),
    .io_rdata (io_rdata),
    .count    (count),
    .tc       (tc),
    .en_clr   (tc_set && ctrl[CTRL_ONESHOT]),
    .ctrl     (ctrl),
    .reload   (reload),
    .presc    (presc),
`ifdef MICO8_TMR_PWM_EN
    .cmp      (cmp),
`endif
    .en_rise  (en_rise),
    .tc_wclr  (tc_wclr)
  );

  assign ps_wrap = (pcnt == PRESCALE_W'(presc));
  assign tc_set  = ctrl[CTRL_EN] && ps_wrap && (count == '0);
  assign tc_clr  = tc_wclr || (intr_ack && (state == PEND));
  assign tick    = tc_set && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt  <= '0;
      count <= RESET_RELOAD;
    end else if (en_rise) begin
      pcnt  <= '0;
      count <= reload;
    end else if (ctrl[CTRL_EN]) begin
      if (ps_wrap) begin
        pcnt  <= '0;
        count <= (count == '0) ? reload : count - 16'd1;
      end else begin
        pcnt  <= pcnt + PRESCALE_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)         tc <= 1'b0;
    else if (tc_set) tc <= 1'b1;
    else if (tc_clr) tc <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (tc_set && !tc && ctrl[CTRL_IE]) state_n = PEND;
      PEND: begin
        if (!ctrl[CTRL_IE])        state_n = IDLE;
        else if (tc_clr && !tc_set) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    intr = (state == PEND);
  end

`ifdef MICO8_TMR_PWM_EN
  always_ff @(posedge clk) begin
    if (rst) pwm_out <= 1'b0;
    else     pwm_out <= ctrl[CTRL_EN] && (count[7:0] < cmp);
  end
`endif

endmodule

// File: tb/tb_mico8_io_timer.sv
// Self-checking bench for mico8_io_timer: table vectors, directed corner
// sequences and randomized traffic against a cycle-level behavioural model.
module tb_mico8_io_timer;

  localparam logic [7:0] BASE = 8'h10;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] io_addr, io_wdata, io_rdata;
  logic       io_wr, io_rd, intr, intr_ack, tick;
`ifdef MICO8_TMR_PWM_EN
  logic       pwm_out;
`endif

  always #5 clk = ~clk;

  mico8_io_timer #(
    .BASE_ADDR    (BASE),
    .PRESCALE_W   (8),
    .RESET_RELOAD (16'hFFFF)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .io_addr  (io_addr),
    .io_wdata (io_wdata),
    .io_wr    (io_wr),
    .io_rd    (io_rd),
    .io_rdata (io_rdata),
    .intr     (intr),
    .intr_ack (intr_ack),
    .tick     (tick)
`ifdef MICO8_TMR_PWM_EN
    ,.pwm_out (pwm_out)
`endif
  );

  int checks = 0;
  int errors = 0;

  // behavioural model state
  int m_en, m_ie, m_os, m_tc, m_pend, m_pwm;
  int m_reload, m_presc, m_phase, m_count, m_shadow, m_cmp;

  // samples from the most recent cycle
  int s_rdata, s_tick, s_intr;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_en = 0; m_ie = 0; m_os = 0; m_tc = 0; m_pend = 0; m_pwm = 0;
    m_reload = 16'hFFFF; m_count = 16'hFFFF;
    m_presc = 0; m_phase = 0; m_shadow = 0; m_cmp = 0;
  endtask

  function automatic int model_rdata(input int a, input int r);
    if (!r || (a >> 3) != (BASE >> 3)) return 0;
    case (a & 7)
      0: return m_en | (m_ie << 1) | (m_os << 2);
      1: return m_tc;
      2: return m_reload & 255;
      3: return m_reload >> 8;
      4: return m_presc;
      5: return m_count & 255;
      6: return m_shadow;
`ifdef MICO8_TMR_PWM_EN
      7: return m_cmp;
`endif
      default: return 0;
    endcase
  endfunction

  task automatic model_step(input int a, input int d, input int w, input int r, input int k);
    int sel, ofs, wr_, ev, tcs, clr;
    int n_pend, n_tc, n_count, n_phase, n_en, n_ie, n_os, n_reload, n_presc, n_shadow, n_cmp;
    sel = ((a >> 3) == (BASE >> 3));
    ofs = a & 7;
    wr_ = w && sel;
    ev  = m_en && (m_phase == m_presc);
    tcs = ev && (m_count == 0);
    clr = (wr_ && ofs == 1 && (d & 1)) || (k && m_pend);
    if (!m_pend) n_pend = tcs && !m_tc && m_ie;
    else if (!m_ie) n_pend = 0;
    else n_pend = !(clr && !tcs);
    n_tc = tcs ? 1 : (clr ? 0 : m_tc);
    n_count = m_count; n_phase = m_phase;
    if (wr_ && ofs == 0 && (d & 1) && !m_en) begin
      n_count = m_reload; n_phase = 0;
    end else if (m_en) begin
      if (ev) begin
        n_phase = 0;
        n_count = (m_count == 0) ? m_reload : m_count - 1;
      end else n_phase = m_phase + 1;
    end
    n_en = m_en; n_ie = m_ie; n_os = m_os;
    n_reload = m_reload; n_presc = m_presc; n_cmp = m_cmp; n_shadow = m_shadow;
    if (tcs && m_os) n_en = 0;
    if (wr_) begin
      case (ofs)
        0: begin n_en = d & 1; n_ie = (d >> 1) & 1; n_os = (d >> 2) & 1; end
        2: n_reload = (m_reload & 16'hFF00) | d;
        3: n_reload = (m_reload & 255) | (d << 8);
        4: n_presc = d;
`ifdef MICO8_TMR_PWM_EN
        7: n_cmp = d;
`endif
        default: ;
      endcase
    end
    if (r && sel && ofs == 5) n_shadow = m_count >> 8;
    m_pwm = m_en && ((m_count % 256) < m_cmp);
    m_pend = n_pend; m_tc = n_tc; m_count = n_count; m_phase = n_phase;
    m_en = n_en; m_ie = n_ie; m_os = n_os; m_reload = n_reload;
    m_presc = n_presc; m_cmp = n_cmp; m_shadow = n_shadow;
  endtask

  // One bus cycle: drive, sample mid-cycle against the model, advance model and clock.
  task automatic do_cycle(input logic [7:0] a, input logic [7:0] d, input logic w,
                          input logic r, input logic k);
    int e_rd, e_tk, e_ir;
    io_addr = a; io_wdata = d; io_wr = w; io_rd = r; intr_ack = k;
    e_rd = model_rdata(a, r);
    e_tk = m_en && (m_phase == m_presc) && (m_count == 0);
    e_ir = m_pend;
    #4;
    s_rdata = io_rdata; s_tick = tick; s_intr = intr;
    chk("model_rdata", s_rdata, e_rd);
    chk("model_tick", s_tick, e_tk);
    chk("model_intr", s_intr, e_ir);
`ifdef MICO8_TMR_PWM_EN
    chk("model_pwm", pwm_out, m_pwm);
`endif
    model_step(a, d, w, r, k);
    @(posedge clk); #1;
  endtask

  task automatic wr_reg(input logic [2:0] o, input logic [7:0] d);
    do_cycle(BASE | 8'(o), d, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic rd_reg(input logic [2:0] o);
    do_cycle(BASE | 8'(o), 8'h00, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic idle();
    do_cycle(8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    io_addr = '0; io_wdata = '0; io_wr = 1'b0; io_rd = 1'b0; intr_ack = 1'b0;
    repeat (2) begin
      #4;
      chk("rst_tick", tick, 0);
      @(posedge clk); #1;
    end
    model_reset();
    rst = 1'b0;
  endtask

  typedef struct {
    logic [7:0] addr;
    logic [7:0] exp_rdata;
    logic       exp_intr;
  } vec_t;

  vec_t tbl[9];
  int first_tick, n_ticks, bad_gap, first_intr;

  initial begin
    tbl[0] = '{8'h10, 8'h00, 1'b0};
    tbl[1] = '{8'h11, 8'h00, 1'b0};
    tbl[2] = '{8'h12, 8'hFF, 1'b0};
    tbl[3] = '{8'h13, 8'hFF, 1'b0};
    tbl[4] = '{8'h14, 8'h00, 1'b0};
    tbl[5] = '{8'h15, 8'hFF, 1'b0};
    tbl[6] = '{8'h16, 8'hFF, 1'b0};
    tbl[7] = '{8'h17, 8'h00, 1'b0};
    tbl[8] = '{8'h20, 8'h00, 1'b0};

    rst = 1'b1;
    io_addr = '0; io_wdata = '0; io_wr = 1'b0; io_rd = 1'b0; intr_ack = 1'b0;
    model_reset();
    @(posedge clk); #1;
    do_reset();

    // reset readback of every offset plus an unselected address
    for (int i = 0; i < 9; i++) begin
      do_cycle(tbl[i].addr, 8'h00, 1'b0, 1'b1, 1'b0);
      chk("tbl_rdata", s_rdata, tbl[i].exp_rdata);
      chk("tbl_intr", s_intr, tbl[i].exp_intr);
    end

    // periodic: RELOAD=3, PRESC=1 -> tick every 8 clocks, intr one cycle later
    wr_reg(3'd2, 8'h03); wr_reg(3'd3, 8'h00); wr_reg(3'd4, 8'h01); wr_reg(3'd0, 8'h03);
    first_tick = 0; n_ticks = 0; bad_gap = 0; first_intr = 0;
    for (int k = 1; k <= 26; k++) begin
      idle();
      if (s_tick) begin
        if (first_tick == 0) first_tick = k;
        if (k % 8 != 0) bad_gap++;
        n_ticks++;
      end
      if (s_intr && first_intr == 0) first_intr = k;
    end
    chk("per_first_tick", first_tick, 8);
    chk("per_n_ticks", n_ticks, 3);
    chk("per_gap", bad_gap, 0);
    chk("per_intr_lat", first_intr, 9);
    do_cycle(8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("ack_pre_intr", s_intr, 1);
    rd_reg(3'd1);
    chk("ack_intr_drop", s_intr, 0);
    chk("ack_status", s_rdata, 8'h00);
    wr_reg(3'd0, 8'h00);

    // one-shot: RELOAD=2, PRESC=0
    wr_reg(3'd2, 8'h02); wr_reg(3'd3, 8'h00); wr_reg(3'd4, 8'h00);
    wr_reg(3'd1, 8'h01); wr_reg(3'd0, 8'h05);
    first_tick = 0; n_ticks = 0;
    for (int k = 1; k <= 53; k++) begin
      idle();
      if (s_tick) begin
        if (first_tick == 0) first_tick = k;
        n_ticks++;
      end
    end
    chk("os_first_tick", first_tick, 3);
    chk("os_n_ticks", n_ticks, 1);
    rd_reg(3'd0);
    chk("os_ctrl", s_rdata, 8'h04);
    chk("os_intr", s_intr, 0);

    // coherent COUNT read across a borrow from 0x0100
    wr_reg(3'd2, 8'h00); wr_reg(3'd3, 8'h01); wr_reg(3'd0, 8'h01);
    rd_reg(3'd5);
    chk("coh_lo", s_rdata, 8'h00);
    repeat (5) idle();
    rd_reg(3'd6);
    chk("coh_hi", s_rdata, 8'h01);
    wr_reg(3'd0, 8'h00);

    // ack colliding with a new terminal count: RELOAD=0, PRESC=1
    wr_reg(3'd2, 8'h00); wr_reg(3'd3, 8'h00); wr_reg(3'd4, 8'h01);
    wr_reg(3'd1, 8'h01); wr_reg(3'd0, 8'h03);
    idle();
    idle();
    chk("coll_tick1", s_tick, 1);
    idle();
    chk("coll_intr_up", s_intr, 1);
    do_cycle(8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("coll_tick2", s_tick, 1);
    rd_reg(3'd1);
    chk("coll_status", s_rdata, 8'h01);
    chk("coll_intr", s_intr, 1);
    wr_reg(3'd0, 8'h00);
    wr_reg(3'd1, 8'h01);
    idle();
    chk("coll_cleared", s_intr, 0);

    // unselected writes and reads leave the block untouched
    do_cycle(8'h20, 8'h07, 1'b1, 1'b0, 1'b0);
    do_cycle(8'h22, 8'hAA, 1'b1, 1'b0, 1'b0);
    do_cycle(8'h24, 8'h55, 1'b1, 1'b0, 1'b0);
    do_cycle(8'h20, 8'h00, 1'b0, 1'b1, 1'b0);
    chk("unsel_rd", s_rdata, 8'h00);
    rd_reg(3'd0); chk("unsel_ctrl", s_rdata, 8'h00);
    rd_reg(3'd2); chk("unsel_rld_lo", s_rdata, 8'h00);
    rd_reg(3'd4); chk("unsel_presc", s_rdata, 8'h01);

    // reset while ticking every cycle
    wr_reg(3'd4, 8'h00); wr_reg(3'd0, 8'h01);
    idle();
    chk("pre_rst_tick", s_tick, 1);
    do_reset();
    rd_reg(3'd0); chk("post_rst_ctrl", s_rdata, 8'h00);
    rd_reg(3'd5); chk("post_rst_cnt_lo", s_rdata, 8'hFF);
    rd_reg(3'd3); chk("post_rst_rld_hi", s_rdata, 8'hFF);
    chk("post_rst_intr", s_intr, 0);

    // randomized traffic against the model
    for (int n = 0; n < 1500; n++) begin
      logic [2:0] o;
      logic [7:0] a, d;
      o = 3'($urandom_range(0, 7));
      a = ($urandom_range(0, 9) == 0) ? 8'($urandom) : (BASE | 8'(o));
      case (a[2:0])
        3'd2:    d = 8'($urandom_range(0, 15));
        3'd3:    d = 8'($urandom_range(0, 1));
        3'd4:    d = 8'($urandom_range(0, 3));
        default: d = 8'($urandom);
      endcase
      do_cycle(a, d, ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
               ($urandom_range(0, 9) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
